// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with enable and three
// operating modes: LEVEL (plain registered decode), PULSE (one-shot of
// HOLD_CYC cycles started by a load strobe) and SCAN (automatic sweep across
// all outputs, dwelling HOLD_CYC cycles on each, with load-to-jump).
module scan_decoder #(
    parameter  int SEL_W    = 4,
    parameter  int HOLD_CYC = 4,
    localparam int OUT_W    = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    output logic [OUT_W-1:0] d,
    output logic [SEL_W-1:0] idx,
    output logic             busy
);

    localparam int               CNT_W = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(HOLD_CYC - 1);

    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_SCAN  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] d_q, d_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_prev_q;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Next-state and next-output logic. Any mode change wins over everything
    // and parks the block in IDLE with outputs cleared (idx is kept).
    // In SCAN, cnt counts the display cycles already spent on idx; an edge
    // that only turns the output back on (entry or resume after en=0) does
    // not consume dwell, so a resumed index gets its remaining HOLD_CYC-cnt.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        if (mode != mode_prev_q) begin
            state_d = ST_IDLE;
            d_d     = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    d_d    = '0;
                    busy_d = 1'b0;
                    cnt_d  = '0;
                    if (mode == MODE_PULSE) begin
                        if (en && load) begin
                            idx_d   = sel;
                            d_d     = onehot(sel);
                            busy_d  = 1'b1;
                            state_d = ST_PULSE;
                        end
                    end else if (mode == MODE_SCAN) begin
                        if (en) begin
                            state_d = ST_SCAN;
                        end
                    end else if (en) begin
                        // LEVEL and the reserved encoding
                        d_d   = onehot(sel);
                        idx_d = sel;
                    end
                end
                ST_PULSE: begin
                    if (!en || cnt_q == TERM) begin
                        d_d     = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SCAN: begin
                    busy_d = 1'b0;
                    if (!en) begin
                        d_d = '0;
                    end else if (load) begin
                        idx_d = sel;
                        cnt_d = '0;
                        d_d   = onehot(sel);
                    end else if (d_q == '0) begin
                        d_d = onehot(idx_q);
                    end else if (cnt_q == TERM) begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                        d_d   = onehot(idx_d);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        d_d   = onehot(idx_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    d_d     = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset asserts asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            d_q         <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            mode_prev_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            mode_prev_q <= mode;
        end
    end

    assign d    = d_q;
    assign idx  = idx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: four instances (SEL_W/HOLD_CYC = 4/4, 4/2, 2/1, 3/1)
// share one stimulus stream. A countdown-based behavioural model tracks each
// instance and is compared every cycle; directed sequences pin literal values.
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  sel = 4'd0;
    logic        load = 1'b0;

    logic [15:0] d0, d1;
    logic [3:0]  d2;
    logic [7:0]  d3;
    logic [3:0]  i0, i1;
    logic [1:0]  i2;
    logic [2:0]  i3;
    logic        b0, b1, b2, b3;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(4), .HOLD_CYC(4)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel(sel), .load(load), .d(d0), .idx(i0), .busy(b0));
    scan_decoder #(.SEL_W(4), .HOLD_CYC(2)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel(sel), .load(load), .d(d1), .idx(i1), .busy(b1));
    scan_decoder #(.SEL_W(2), .HOLD_CYC(1)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel(sel[1:0]), .load(load), .d(d2), .idx(i2), .busy(b2));
    scan_decoder #(.SEL_W(3), .HOLD_CYC(1)) u3 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel(sel[2:0]), .load(load), .d(d3), .idx(i3), .busy(b3));

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 pulse, 2 scan. left = cycles of display still owed.
    int ow[4] = '{16, 16, 4, 8};
    int hc[4] = '{4, 2, 1, 1};
    int m_ph[4], m_idx[4], m_left[4], m_on[4], m_busy[4], m_prev[4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_ph[k] = 0; m_idx[k] = 0; m_left[k] = 0;
            m_on[k] = 0; m_busy[k] = 0; m_prev[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int s;
        s = int'(sel) % ow[k];
        if (int'(mode) != m_prev[k]) begin
            m_ph[k] = 0; m_on[k] = 0; m_busy[k] = 0;
        end else if (m_ph[k] == 0) begin
            m_on[k] = 0; m_busy[k] = 0;
            if (mode == 2'd1) begin
                if (en && load) begin
                    m_idx[k] = s; m_on[k] = 1; m_busy[k] = 1;
                    m_left[k] = hc[k]; m_ph[k] = 1;
                end
            end else if (mode == 2'd2) begin
                if (en) begin
                    m_ph[k] = 2; m_left[k] = hc[k];
                end
            end else if (en) begin
                m_on[k] = 1; m_idx[k] = s;
            end
        end else if (m_ph[k] == 1) begin
            m_left[k]--;
            if (!en || m_left[k] == 0) begin
                m_on[k] = 0; m_busy[k] = 0; m_ph[k] = 0;
            end
        end else begin
            if (!en) m_on[k] = 0;
            else if (load) begin
                m_idx[k] = s; m_left[k] = hc[k]; m_on[k] = 1;
            end else if (m_on[k] == 0) m_on[k] = 1;
            else begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_idx[k] = (m_idx[k] + 1) % ow[k];
                    m_left[k] = hc[k];
                end
            end
        end
        m_prev[k] = int'(mode);
    endtask

    // Model advances on the same edges the DUTs see.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else for (int k = 0; k < 4; k++) model_step(k);
    end

    function automatic logic [31:0] act_d(input int k);
        case (k)
            0: return {16'b0, d0};
            1: return {16'b0, d1};
            2: return {28'b0, d2};
            default: return {24'b0, d3};
        endcase
    endfunction

    function automatic logic [31:0] act_i(input int k);
        case (k)
            0: return {28'b0, i0};
            1: return {28'b0, i1};
            2: return {30'b0, i2};
            default: return {29'b0, i3};
        endcase
    endfunction

    function automatic logic [31:0] act_b(input int k);
        case (k)
            0: return {31'b0, b0};
            1: return {31'b0, b1};
            2: return {31'b0, b2};
            default: return {31'b0, b3};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("model_d[%0d]", k), act_d(k),
                    (m_on[k] != 0) ? (32'd1 << m_idx[k]) : 32'd0);
                chk($sformatf("model_idx[%0d]", k), act_i(k), 32'(m_idx[k]));
                chk($sformatf("model_busy[%0d]", k), act_b(k), 32'(m_busy[k]));
                chk($sformatf("onehot[%0d]", k), 32'($countones(act_d(k)) <= 1), 32'd1);
            end
        end
    end

    // Apply inputs now, return at the next falling edge (outputs then reflect them).
    task automatic cycle(input logic e, input logic [1:0] m, input logic [3:0] s, input logic l);
        en = e; mode = m; sel = s; load = l;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        chk("rst_d", {16'b0, d0}, 32'h0);
        chk("rst_idx", {28'b0, i0}, 32'h0);
        chk("rst_busy", {31'b0, b0}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // LEVEL decode
        cycle(1, 0, 5, 0);  chk("lvl_sel5", {16'b0, d0}, 32'h0020);
        chk("lvl_idx5", {28'b0, i0}, 32'd5);
        cycle(0, 0, 5, 0);  chk("lvl_en0", {16'b0, d0}, 32'h0);
        chk("lvl_idx_hold", {28'b0, i0}, 32'd5);
        cycle(1, 0, 15, 0); chk("lvl_sel15", {16'b0, d0}, 32'h8000);

        // PULSE: mode change clears, 4-cycle pulse, ignored reload, back-to-back, abort
        cycle(1, 1, 3, 0);  chk("pls_modechg", {16'b0, d0}, 32'h0);
        cycle(1, 1, 3, 1);  chk("pls_c1_d", {16'b0, d0}, 32'h0008);
        chk("pls_c1_busy", {31'b0, b0}, 32'd1);
        for (int p = 2; p <= 4; p++) begin
            cycle(1, 1, 7, (p == 3));
            chk("pls_hold_d", {16'b0, d0}, 32'h0008);
            chk("pls_hold_busy", {31'b0, b0}, 32'd1);
        end
        cycle(1, 1, 7, 0);  chk("pls_end_d", {16'b0, d0}, 32'h0);
        chk("pls_end_busy", {31'b0, b0}, 32'd0);
        chk("pls_end_idx", {28'b0, i0}, 32'd3);
        cycle(1, 1, 2, 1);  chk("pls_b2b_d", {16'b0, d0}, 32'h0004);
        cycle(0, 1, 2, 0);  chk("pls_abort_d", {16'b0, d0}, 32'h0);
        chk("pls_abort_busy", {31'b0, b0}, 32'd0);

        // PULSE busy, then switch to SCAN
        cycle(1, 1, 6, 1);  chk("sw_busy", {31'b0, b0}, 32'd1);
        cycle(1, 2, 6, 0);  chk("sw_d", {16'b0, d0}, 32'h0);
        chk("sw_busy0", {31'b0, b0}, 32'd0);
        cycle(1, 2, 6, 0);  chk("sw_entry_d", {16'b0, d0}, 32'h0);
        cycle(1, 2, 6, 0);  chk("sw_scan_d", {16'b0, d0}, 32'h0040);

        // SCAN jump at terminal count, freeze, resume
        cycle(1, 2, 4, 1);  chk("jmp4_d", {16'b0, d0}, 32'h0010);
        for (int j = 1; j <= 3; j++) begin
            cycle(1, 2, 4, 0); chk("dwell4_d", {16'b0, d0}, 32'h0010);
        end
        cycle(1, 2, 9, 1);  chk("jmp9_d", {16'b0, d0}, 32'h0200);
        chk("jmp9_idx", {28'b0, i0}, 32'd9);
        for (int j = 0; j < 3; j++) begin
            cycle(0, 2, 9, 0);
            chk("frz_d", {16'b0, d0}, 32'h0);
            chk("frz_idx", {28'b0, i0}, 32'd9);
        end
        cycle(1, 2, 9, 0);  chk("resume_d", {16'b0, d0}, 32'h0200);
        chk("resume_busy", {31'b0, b0}, 32'd0);

        // SCAN from reset: full sweep on all instances
        #1 rst_n = 1'b0;
        en = 1'b1; mode = 2'd2; sel = 4'd0; load = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        w = 0;
        while (d1 == 16'd0 && w < 12) begin
            @(negedge clk);
            w++;
        end
        chk("scan_start", {16'b0, d1}, 32'h0001);
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            chk("sweep_h4", {16'b0, d0}, 32'd1 << ((k / 4) % 16));
            chk("sweep_h2", {16'b0, d1}, 32'd1 << ((k / 2) % 16));
            chk("sweep_w2", {28'b0, d2}, 32'd1 << (k % 4));
            chk("sweep_w3", {24'b0, d3}, 32'd1 << (k % 8));
        end

        // Asynchronous reset in the middle of a pulse
        cycle(1, 1, 5, 0);
        cycle(1, 1, 5, 1);  chk("arst_pre_d", {16'b0, d0}, 32'h0020);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_d", {16'b0, d0}, 32'h0);
        chk("arst_busy", {31'b0, b0}, 32'd0);
        chk("arst_idx", {28'b0, i0}, 32'd0);
        cycle(0, 0, 0, 0);
        #2 rst_n = 1'b1;

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] m;
            m = mode;
            if ($urandom_range(0, 39) == 0) m = 2'($urandom);
            cycle(($urandom_range(0, 9) != 0), m, 4'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
